atm_ctrl_multi: RTL and testbench

Parametrised next-generation ATM session controller: holds a provisionable table of `NUM_ACCOUNTS` accounts (number, PIN, balance), authenticates a session, then serves balance, withdraw, withdraw-and-show, transfer and deposit requests over a valid/done handshake. It adds per-account PIN lockout, typed error codes, provisioning writes and an optional inactivity timeout. It sits between the card/keypad front end and the display logic.

---
 rtl/atm_pkg.sv | 45 ++++
 rtl/atm_acct_scan.sv | 66 ++++++
 rtl/atm_ctrl_multi.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_atm_ctrl_multi.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// atm_pkg: state, menu and error encodings plus the account-table entry shared by the ATM controller.
// Entry field widths here bound the ACC_W/PIN_W/BAL_W parameters of atm_ctrl_multi.
package atm_pkg;

  localparam int ACC_W_PKG = 12;
  localparam int PIN_W_PKG = 4;
  localparam int BAL_W_PKG = 11;
  localparam int FAIL_W    = 4;

  typedef enum logic [2:0] {
    S_WAITING    = 3'd0,
    S_LOGIN_SCAN = 3'd1,
    S_MENU       = 3'd2,
    S_EXEC       = 3'd3,
    S_DEST_SCAN  = 3'd4,
    S_DONE       = 3'd5
  } state_e;

  localparam logic [3:0] OPT_BALANCE       = 4'd3;
  localparam logic [3:0] OPT_WITHDRAW      = 4'd4;
  localparam logic [3:0] OPT_WITHDRAW_SHOW = 4'd5;
  localparam logic [3:0] OPT_TRANSACTION   = 4'd6;
  localparam logic [3:0] OPT_DEPOSIT       = 4'd7;

  typedef enum logic [2:0] {
    ERR_OK       = 3'd0,
    ERR_NO_ACCT  = 3'd1,
    ERR_BAD_PIN  = 3'd2,
    ERR_LOCKED   = 3'd3,
    ERR_FUNDS    = 3'd4,
    ERR_OVERFLOW = 3'd5,
    ERR_BAD_DEST = 3'd6,
    ERR_BAD_OPT  = 3'd7
  } err_e;

  typedef struct packed {
    logic                 valid;
    logic [ACC_W_PKG-1:0] acc;
    logic [PIN_W_PKG-1:0] pin;
    logic [BAL_W_PKG-1:0] bal;
    logic [FAIL_W-1:0]    fails;
    logic                 lock;
  } entry_t;

endpackage

// File: rtl/atm_acct_scan.sv
// atm_acct_scan: walks the account table one slot per cycle looking for a key.
// Reports a one-cycle hit (with slot index) or miss after the last slot; abort cancels a scan.
module atm_acct_scan
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 10,
  parameter int ACC_W        = ACC_W_PKG,
  parameter int IDX_W        = $clog2(NUM_ACCOUNTS)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start_i,
  input  logic                               abort_i,
  input  logic [ACC_W-1:0]                   key_i,
  input  logic [NUM_ACCOUNTS-1:0]            valid_i,
  input  logic [NUM_ACCOUNTS-1:0][ACC_W-1:0] acc_i,
  output logic                               hit_o,
  output logic                               miss_o,
  output logic [IDX_W-1:0]                   index_o
);

  logic             active_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] index_q;
  logic [ACC_W-1:0] key_q;
  logic             hit_q;
  logic             miss_q;

  // The key is latched at start so the caller may change its inputs mid-scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      index_q  <= '0;
      key_q    <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      if (abort_i) begin
        active_q <= 1'b0;
      end else if (start_i) begin
        active_q <= 1'b1;
        idx_q    <= '0;
        key_q    <= key_i;
      end else if (active_q) begin
        if (valid_i[idx_q] && (acc_i[idx_q] == key_q)) begin
          hit_q    <= 1'b1;
          index_q  <= idx_q;
          active_q <= 1'b0;
        end else if (idx_q == IDX_W'(NUM_ACCOUNTS - 1)) begin
          miss_q   <= 1'b1;
          active_q <= 1'b0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign hit_o   = hit_q;
  assign miss_o  = miss_q;
  assign index_o = index_q;

endmodule

// File: rtl/atm_ctrl_multi.sv
// atm_ctrl_multi: multi-account ATM session controller with PIN lockout, typed errors and provisioning.
// Define ATM_TIMEOUT_EN to build the MENU inactivity timeout; without it a session lasts until exit.
module atm_ctrl_multi
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS   = 10,
  parameter int ACC_W          = ACC_W_PKG,
  parameter int PIN_W          = PIN_W_PKG,
  parameter int BAL_W          = BAL_W_PKG,
  parameter int MAX_PIN_TRIES  = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            req_valid,
  input  logic                            exit,
  input  logic [ACC_W-1:0]                acc_number,
  input  logic [PIN_W-1:0]                pin,
  input  logic [3:0]                      menu_option,
  input  logic [ACC_W-1:0]                dest_acc_number,
  input  logic [BAL_W-1:0]                amount,
  input  logic                            prog_we,
  input  logic [$clog2(NUM_ACCOUNTS)-1:0] prog_idx,
  input  logic [ACC_W-1:0]                prog_acc,
  input  logic [PIN_W-1:0]                prog_pin,
  input  logic [BAL_W-1:0]                prog_bal,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [2:0]                      err_code,
  output logic [BAL_W-1:0]                balance,
  output logic                            in_session
);

  localparam int IDX_W = $clog2(NUM_ACCOUNTS);

  state_e           state_q;
  state_e           ret_q;
  entry_t           tbl_q [NUM_ACCOUNTS];
  logic [IDX_W-1:0] sessIdx_q;
  logic [BAL_W-1:0] balance_q;
  logic [BAL_W-1:0] amount_q;
  logic [PIN_W-1:0] pin_q;
  logic [3:0]       opt_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic             inSession_q;
  err_e             errCode_q;

  logic                               scanStart;
  logic [ACC_W-1:0]                   scanKey;
  logic                               scanHit;
  logic                               scanMiss;
  logic [IDX_W-1:0]                   scanIdx;
  logic [NUM_ACCOUNTS-1:0]            validVec;
  logic [NUM_ACCOUNTS-1:0][ACC_W-1:0] accVec;

  logic              finish;
  err_e              resCode;
  state_e            resRet;
  logic [BAL_W-1:0]  sessBal;
  logic [BAL_W-1:0]  destBal;
  logic [BAL_W:0]    depSum;
  logic [BAL_W:0]    xferSum;
  logic [FAIL_W-1:0] failsInc;

`ifdef ATM_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idleCnt_q;
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    for (int i = 0; i < NUM_ACCOUNTS; i++) begin
      validVec[i] = tbl_q[i].valid;
      accVec[i]   = tbl_q[i].acc[ACC_W-1:0];
    end
  end

  // One scanner serves both login and transfer-destination lookups; exit aborts it.
  always_comb begin
    scanStart = 1'b0;
    scanKey   = acc_number;
    if (req_valid && !exit) begin
      if (state_q == S_WAITING && !prog_we) begin
        scanStart = 1'b1;
      end else if (state_q == S_MENU && menu_option == OPT_TRANSACTION) begin
        scanStart = 1'b1;
        scanKey   = dest_acc_number;
      end
    end
  end

  atm_acct_scan #(
    .NUM_ACCOUNTS(NUM_ACCOUNTS),
    .ACC_W       (ACC_W),
    .IDX_W       (IDX_W)
  ) u_scan (
    .clk    (clk),
    .reset_n(reset_n),
    .start_i(scanStart),
    .abort_i(exit),
    .key_i  (scanKey),
    .valid_i(validVec),
    .acc_i  (accVec),
    .hit_o  (scanHit),
    .miss_o (scanMiss),
    .index_o(scanIdx)
  );

  // Outcome of the request in flight; overflow checks use one extra bit.
  always_comb begin
    depSum   = {1'b0, balance_q} + {1'b0, amount_q};
    xferSum  = {1'b0, tbl_q[scanIdx].bal[BAL_W-1:0]} + {1'b0, amount_q};
    failsInc = tbl_q[scanIdx].fails + 1'b1;
    finish   = 1'b0;
    resCode  = ERR_OK;
    resRet   = S_MENU;
    sessBal  = balance_q;
    destBal  = xferSum[BAL_W-1:0];
    case (state_q)
      S_LOGIN_SCAN: begin
        resRet = S_WAITING;
        if (scanMiss) begin
          finish  = 1'b1;
          resCode = ERR_NO_ACCT;
        end else if (scanHit) begin
          finish = 1'b1;
          if (tbl_q[scanIdx].lock) begin
            resCode = ERR_LOCKED;
          end else if (tbl_q[scanIdx].pin[PIN_W-1:0] != pin_q) begin
            resCode = ERR_BAD_PIN;
          end else begin
            resRet = S_MENU;
          end
        end
      end
      S_EXEC: begin
        finish = 1'b1;
        case (opt_q)
          OPT_BALANCE: sessBal = balance_q;
          OPT_WITHDRAW, OPT_WITHDRAW_SHOW: begin
            if (amount_q > balance_q) resCode = ERR_FUNDS;
            else sessBal = balance_q - amount_q;
          end
          OPT_DEPOSIT: begin
            if (depSum[BAL_W]) resCode = ERR_OVERFLOW;
            else sessBal = depSum[BAL_W-1:0];
          end
          default: resCode = ERR_BAD_OPT;
        endcase
      end
      S_DEST_SCAN: begin
        if (scanMiss) begin
          finish  = 1'b1;
          resCode = ERR_BAD_DEST;
        end else if (scanHit) begin
          finish = 1'b1;
          if (scanIdx == sessIdx_q) resCode = ERR_BAD_DEST;
          else if (amount_q > balance_q) resCode = ERR_FUNDS;
          else if (xferSum[BAL_W]) resCode = ERR_OVERFLOW;
          else sessBal = balance_q - amount_q;
        end
      end
      default: finish = 1'b0;
    endcase
  end

  // Session FSM and the account table share one block so each table field has a single writer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_WAITING;
      ret_q       <= S_WAITING;
      sessIdx_q   <= '0;
      balance_q   <= '0;
      amount_q    <= '0;
      pin_q       <= '0;
      opt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      inSession_q <= 1'b0;
      errCode_q   <= ERR_OK;
      for (int i = 0; i < NUM_ACCOUNTS; i++) tbl_q[i] <= '0;
`ifdef ATM_TIMEOUT_EN
      idleCnt_q   <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      errCode_q <= ERR_OK;
      if (exit && state_q != S_WAITING) begin
        state_q     <= S_WAITING;
        busy_q      <= 1'b0;
        inSession_q <= 1'b0;
        balance_q   <= '0;
      end else begin
        if (finish) begin
          done_q    <= 1'b1;
          error_q   <= (resCode != ERR_OK);
          errCode_q <= resCode;
          ret_q     <= resRet;
          state_q   <= S_DONE;
        end
        case (state_q)
          S_WAITING: begin
            if (prog_we) begin
              if (32'(prog_idx) < NUM_ACCOUNTS) begin
                tbl_q[prog_idx] <= '{valid: 1'b1,
                                     acc:   ACC_W_PKG'(prog_acc),
                                     pin:   PIN_W_PKG'(prog_pin),
                                     bal:   BAL_W_PKG'(prog_bal),
                                     fails: '0,
                                     lock:  1'b0};
              end
            end else if (req_valid && !exit) begin
              pin_q   <= pin;
              busy_q  <= 1'b1;
              state_q <= S_LOGIN_SCAN;
            end
          end
          S_LOGIN_SCAN: begin
            if (finish && resCode == ERR_BAD_PIN) begin
              tbl_q[scanIdx].fails <= failsInc;
              if (failsInc >= FAIL_W'(MAX_PIN_TRIES)) tbl_q[scanIdx].lock <= 1'b1;
            end else if (finish && resCode == ERR_OK) begin
              tbl_q[scanIdx].fails <= '0;
              sessIdx_q            <= scanIdx;
              balance_q            <= tbl_q[scanIdx].bal[BAL_W-1:0];
              inSession_q          <= 1'b1;
            end
          end
          S_MENU: begin
            if (req_valid) begin
              opt_q    <= menu_option;
              amount_q <= amount;
              busy_q   <= 1'b1;
              state_q  <= (menu_option == OPT_TRANSACTION) ? S_DEST_SCAN : S_EXEC;
`ifdef ATM_TIMEOUT_EN
              idleCnt_q <= '0;
            end else if (idleCnt_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
              state_q     <= S_WAITING;
              inSession_q <= 1'b0;
              balance_q   <= '0;
              done_q      <= 1'b1;
              idleCnt_q   <= '0;
            end else begin
              idleCnt_q <= idleCnt_q + 1'b1;
`endif
            end
          end
          S_EXEC: begin
            if (resCode == ERR_OK) begin
              balance_q             <= sessBal;
              tbl_q[sessIdx_q].bal  <= BAL_W_PKG'(sessBal);
            end
          end
          S_DEST_SCAN: begin
            if (finish && resCode == ERR_OK) begin
              balance_q            <= sessBal;
              tbl_q[sessIdx_q].bal <= BAL_W_PKG'(sessBal);
              tbl_q[scanIdx].bal   <= BAL_W_PKG'(destBal);
            end
          end
          S_DONE: begin
            state_q <= ret_q;
            busy_q  <= 1'b0;
`ifdef ATM_TIMEOUT_EN
            idleCnt_q <= '0;
`endif
          end
          default: begin
            state_q <= S_WAITING;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = errCode_q;
  assign balance    = balance_q;
  assign in_session = inSession_q;

endmodule

// File: tb/tb_atm_ctrl_multi.sv
// tb_atm_ctrl_multi: directed self-checking bench for atm_ctrl_multi with hand-computed expectations.
// Latencies are counted in clock edges after the request-accept edge.
module tb_atm_ctrl_multi;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        exitIn = 1'b0;
  logic [11:0] acc_number = '0;
  logic [3:0]  pin = '0;
  logic [3:0]  menu_option = '0;
  logic [11:0] dest_acc_number = '0;
  logic [10:0] amount = '0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_idx = '0;
  logic [11:0] prog_acc = '0;
  logic [3:0]  prog_pin = '0;
  logic [10:0] prog_bal = '0;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  err_code;
  logic [10:0] balance;
  logic        in_session;

  int   testsRun = 0;
  int   testsFailed = 0;
  int   edges;
  logic sawDone;
  logic [31:0] gotErr, gotError, gotBal, gotSess, gotBusy, postFlags;

  always #5 clk = ~clk;

  atm_ctrl_multi #(
    .NUM_ACCOUNTS(10), .ACC_W(12), .PIN_W(4), .BAL_W(11),
    .MAX_PIN_TRIES(3), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .exit(exitIn),
    .acc_number(acc_number), .pin(pin), .menu_option(menu_option),
    .dest_acc_number(dest_acc_number), .amount(amount),
    .prog_we(prog_we), .prog_idx(prog_idx), .prog_acc(prog_acc),
    .prog_pin(prog_pin), .prog_bal(prog_bal),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .balance(balance), .in_session(in_session)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic ex, input logic [11:0] acc,
                               input logic [3:0] pinV, input logic [3:0] opt,
                               input logic [11:0] dest, input logic [10:0] amt);
    req_valid       = rv;
    exitIn          = ex;
    acc_number      = acc;
    pin             = pinV;
    menu_option     = opt;
    dest_acc_number = dest;
    amount          = amt;
  endtask

  task automatic provision(input logic [3:0] idx, input logic [11:0] acc,
                           input logic [3:0] pinV, input logic [10:0] bal);
    prog_we  = 1'b1;
    prog_idx = idx;
    prog_acc = acc;
    prog_pin = pinV;
    prog_bal = bal;
    step();
    prog_we = 1'b0;
  endtask

  // Issue one request, wait (bounded) for done, capture outputs, then let DONE retire.
  task automatic request(input logic [11:0] acc, input logic [3:0] pinV, input logic [3:0] opt,
                         input logic [11:0] dest, input logic [10:0] amt);
    applyStimulus(1'b1, 1'b0, acc, pinV, opt, dest, amt);
    step();
    req_valid = 1'b0;
    gotBusy   = 32'(busy);
    edges     = 0;
    sawDone   = 1'b0;
    while (!sawDone && edges < 200) begin
      step();
      edges++;
      if (done) begin
        sawDone  = 1'b1;
        gotErr   = 32'(err_code);
        gotError = 32'(error);
        gotBal   = 32'(balance);
        gotSess  = 32'(in_session);
      end
    end
    step();
    postFlags = {29'd0, done, error, |err_code};
  endtask

  task automatic checkResult(input string tag, input int expLat, input int expErr, input int expBal);
    checkOutput({tag, "_done"}, 32'(sawDone), 32'd1);
    checkOutput({tag, "_lat"}, edges, expLat);
    checkOutput({tag, "_err"}, gotErr, expErr);
    checkOutput({tag, "_error"}, gotError, (expErr != 0) ? 32'd1 : 32'd0);
    checkOutput({tag, "_bal"}, gotBal, expBal);
  endtask

  task automatic doExit(input string tag);
    applyStimulus(1'b0, 1'b1, '0, '0, '0, '0, '0);
    step();
    exitIn = 1'b0;
    checkOutput({tag, "_sess"}, 32'(in_session), 32'd0);
    checkOutput({tag, "_bal"}, 32'(balance), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #22;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_errcode", 32'(err_code), 32'd0);
    checkOutput("rst_bal", 32'(balance), 32'd0);
    checkOutput("rst_sess", 32'(in_session), 32'd0);
    reset_n = 1'b1;
    step();

    provision(4'd0, 12'd2178, 4'b0100, 11'd500);
    provision(4'd1, 12'd2816, 4'b0110, 11'd500);

    request(12'd2278, 4'b0100, 4'd0, 12'd0, 11'd0);
    checkResult("login_miss", 11, 1, 0);
    checkOutput("login_miss_busy", gotBusy, 32'd1);
    checkOutput("login_miss_sess", gotSess, 32'd0);
    checkOutput("post_done_flags", postFlags, 32'd0);

    request(12'd2178, 4'b0100, 4'd0, 12'd0, 11'd0);
    checkResult("login_a", 2, 0, 500);
    checkOutput("login_a_sess", gotSess, 32'd1);

    request(12'd0, 4'd0, 4'd5, 12'd0, 11'd100);
    checkResult("wd_show", 1, 0, 400);
    request(12'd0, 4'd0, 4'd4, 12'd0, 11'd2000);
    checkResult("wd_funds", 1, 4, 400);
    request(12'd0, 4'd0, 4'd3, 12'd0, 11'd0);
    checkResult("bal", 1, 0, 400);
    request(12'd0, 4'd0, 4'd9, 12'd0, 11'd10);
    checkResult("bad_opt", 1, 7, 400);

    request(12'd0, 4'd0, 4'd6, 12'd2816, 11'd50);
    checkResult("xfer_ok", 3, 0, 350);
    request(12'd0, 4'd0, 4'd6, 12'd2178, 11'd50);
    checkResult("xfer_self", 2, 6, 350);
    request(12'd0, 4'd0, 4'd6, 12'd999, 11'd50);
    checkResult("xfer_miss", 11, 6, 350);
    doExit("exit1");

    request(12'd2816, 4'b0110, 4'd0, 12'd0, 11'd0);
    checkResult("login_b", 3, 0, 550);
    request(12'd0, 4'd0, 4'd7, 12'd0, 11'd300);
    checkResult("dep_ok", 1, 0, 850);
    request(12'd0, 4'd0, 4'd7, 12'd0, 11'd1500);
    checkResult("dep_ovf", 1, 5, 850);
    request(12'd0, 4'd0, 4'd7, 12'd0, 11'd1197);
    checkResult("dep_max", 1, 0, 2047);
    request(12'd0, 4'd0, 4'd7, 12'd0, 11'd1);
    checkResult("dep_ovf1", 1, 5, 2047);
    request(12'd0, 4'd0, 4'd4, 12'd0, 11'd0);
    checkResult("wd_zero", 1, 0, 2047);
    doExit("exit2");

    request(12'd2178, 4'b0100, 4'd0, 12'd0, 11'd0);
    checkResult("login_a2", 2, 0, 350);
    request(12'd0, 4'd0, 4'd6, 12'd2816, 11'd1);
    checkResult("xfer_ovf", 3, 5, 350);
    request(12'd0, 4'd0, 4'd4, 12'd0, 11'd350);
    checkResult("wd_all", 1, 0, 0);
    doExit("exit3");

    for (int k = 0; k < 3; k++) begin
      request(12'd2816, 4'd0, 4'd0, 12'd0, 11'd0);
      checkResult($sformatf("badpin%0d", k), 3, 2, 0);
    end
    request(12'd2816, 4'b0110, 4'd0, 12'd0, 11'd0);
    checkResult("locked", 3, 3, 0);
    provision(4'd1, 12'd2816, 4'b0110, 11'd500);
    request(12'd2816, 4'b0110, 4'd0, 12'd0, 11'd0);
    checkResult("unlocked", 3, 0, 500);
    doExit("exit4");

    applyStimulus(1'b1, 1'b0, 12'd2278, 4'b0100, 4'd0, 12'd0, 11'd0);
    step();
    req_valid = 1'b0;
    step();
    step();
    exitIn = 1'b1;
    step();
    exitIn  = 1'b0;
    sawDone = done;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_sess", 32'(in_session), 32'd0);
    repeat (15) begin
      step();
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort_nodone", 32'(sawDone), 32'd0);

    prog_we  = 1'b1;
    prog_idx = 4'd2;
    prog_acc = 12'd1234;
    prog_pin = 4'd1;
    prog_bal = 11'd100;
    applyStimulus(1'b1, 1'b0, 12'd1234, 4'd1, 4'd0, 12'd0, 11'd0);
    step();
    prog_we   = 1'b0;
    req_valid = 1'b0;
    checkOutput("collide_busy", 32'(busy), 32'd0);
    sawDone = 1'b0;
    repeat (15) begin
      step();
      if (done) sawDone = 1'b1;
    end
    checkOutput("collide_nodone", 32'(sawDone), 32'd0);
    request(12'd1234, 4'd1, 4'd0, 12'd0, 11'd0);
    checkResult("login_c", 4, 0, 100);

`ifdef ATM_TIMEOUT_EN
    edges   = 0;
    sawDone = 1'b0;
    while (!sawDone && edges < 200) begin
      step();
      edges++;
      if (done) begin
        sawDone = 1'b1;
        gotErr  = 32'(err_code);
      end
    end
    checkOutput("tmo_done", 32'(sawDone), 32'd1);
    checkOutput("tmo_lat", edges, 32'd64);
    checkOutput("tmo_err", gotErr, 32'd0);
    checkOutput("tmo_sess", 32'(in_session), 32'd0);
    checkOutput("tmo_bal", 32'(balance), 32'd0);
`else
    sawDone = 1'b0;
    repeat (100) begin
      step();
      if (done) sawDone = 1'b1;
    end
    checkOutput("idle_nodone", 32'(sawDone), 32'd0);
    checkOutput("idle_sess", 32'(in_session), 32'd1);
    checkOutput("idle_bal", 32'(balance), 32'd100);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
